mem_burst_ctrl: RTL and testbench
=================================

Name: mem_burst_ctrl

Overview:
Parametrised successor to the coprocessor's single-word RAM access wrapper. It owns an inferred synchronous RAM and executes single or burst read/write transactions from one start/done handshake. Addresses auto-increment, and read data is pipelined through a configurable wait-state depth. The coprocessor datapath uses it to move operand and result blocks without issuing one request per word.

Parameters:
DATA_W, 16, data word width in bits
ADDR_W, 8, address width; RAM depth is 2**ADDR_W words
RD_LAT, 2, cycles from address issue to read data valid; legal range 1..4
LEN_W, 4, burst length field width; a transaction moves burst_len+1 words (1..2**LEN_W)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  transaction request; sampled only in IDLE
wr  in  1  1 = write burst, 0 = read burst; sampled with start
base_addr  in  ADDR_W  first word address; sampled with start
burst_len  in  LEN_W  word count minus one; sampled with start
wdata  in  DATA_W  write data
wdata_valid  in  1  wdata is valid this cycle
wdata_ready  out  1  block accepts wdata this cycle
rdata  out  DATA_W  read data
rdata_valid  out  1  rdata valid; one cycle per word, no backpressure
busy  out  1  transaction in progress
done  out  1  one-cycle completion pulse
wrapped  out  1  current/last transaction crossed address 2**ADDR_W-1 -> 0

Behaviour:
- Reset (async, rst_n=0): state IDLE; wdata_ready, rdata_valid, busy, done, wrapped = 0; rdata = 0; read pipeline and address/count registers cleared. RAM contents are not cleared.
- Reset mid-transaction aborts it immediately: no done pulse; in-flight read data is discarded; writes already committed stay in RAM.
- States: IDLE, RD (issuing addresses), RD_DRAIN (waiting for pipeline to empty), WR.
- IDLE: if start=1 at edge T0, latch base_addr, burst_len and wr, and clear wrapped. Go to RD or WR. busy=1 from T0.
- start while busy is ignored; no queuing.
- RD: one address issued per cycle, k = 0..burst_len, word k issued at edge T0+k. After the last issue, go to RD_DRAIN.
- Read data: rdata_valid=1 and rdata=RAM[addr_k] in the cycle following edge T0+RD_LAT+k. Words are back-to-back, in address order, with no gaps. rdata holds its last value when rdata_valid=0.
- RD_DRAIN: go to IDLE on the edge after the last rdata_valid cycle.
- WR: wdata_ready=1. A word is written at each edge where wdata_valid && wdata_ready, and the address increments. Gaps in wdata_valid stall the burst without limit.
- After the (burst_len+1)-th accepted word, wdata_ready drops on the same edge and the state goes to IDLE.
- Completion: on every transition into IDLE (other than by reset), done=1 for exactly one cycle and busy=0 in that same cycle.
- Address arithmetic: addr_next = addr + 1 modulo 2**ADDR_W, with no error.
- wrapped: set sticky when an increment goes from all-ones to 0 with words still remaining. It stays valid until the next accepted start.
- Total latency:
  - Read of L words: done in cycle after edge T0+RD_LAT+L.
  - Write of L words with continuous wdata_valid: done in cycle after edge T0+L.
- Simultaneous events:
  - start in the done cycle is accepted, since the state is already IDLE (back-to-back transactions).
  - wdata_valid outside WR is ignored.
- Widths: counters are LEN_W+1 bits; no truncation of burst_len+1.

Test Plan:
- Single write then read, RD_LAT=2: write 0xBEEF to addr 0x10 (burst_len=0) -> done one cycle after accept. Read addr 0x10 -> rdata_valid exactly once, in cycle after T0+2, rdata=0xBEEF; done in the next cycle.
- Burst write of 4 words 0x1111..0x4444 at 0x20 with wdata_valid low for 2 cycles mid-burst -> wdata_ready held, 4 writes only. Burst read of 0x20, len=3 -> four consecutive rdata_valid cycles 0x1111, 0x2222, 0x3333, 0x4444; done one cycle after the last.
- Wrap: write 3 words at 0xFE (ADDR_W=8) -> data lands at 0xFE, 0xFF, 0x00; wrapped=1 after done. Next start with no crossing -> wrapped=0.
- Busy rejection: pulse start with wr=1, addr 0x40 during an active read burst -> ignored; RAM[0x40] unchanged; exactly one done pulse.
- Back-to-back: assert start in the done cycle of a read -> second transaction accepted; busy low for the done cycle only.
- Async reset: drop rst_n mid read burst after 2 of 8 rdata_valid -> all outputs 0 immediately, no done. After release, reading the prior data returns the previously written values.

Source files
------------

// File: rtl/mem_burst_ctrl_if.sv
// mem_burst_ctrl_if: request/response bundle between the coprocessor datapath
// (master) and mem_burst_ctrl (slave).
//   start/wr/base_addr/burst_len : transaction request, sampled only when idle
//   wdata/wdata_valid/wdata_ready: write-data handshake
//   rdata/rdata_valid            : read-data stream, no backpressure
//   busy/done/wrapped            : transaction status
interface mem_burst_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 4
);
    logic              start;
    logic              wr;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  burst_len;
    logic [DATA_W-1:0] wdata;
    logic              wdata_valid;
    logic              wdata_ready;
    logic [DATA_W-1:0] rdata;
    logic              rdata_valid;
    logic              busy;
    logic              done;
    logic              wrapped;

    modport master (
        output start, wr, base_addr, burst_len, wdata, wdata_valid,
        input  wdata_ready, rdata, rdata_valid, busy, done, wrapped
    );

    modport slave (
        input  start, wr, base_addr, burst_len, wdata, wdata_valid,
        output wdata_ready, rdata, rdata_valid, busy, done, wrapped
    );
endinterface

// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl: burst read/write engine around an inferred synchronous RAM.
// One start/done handshake moves burst_len+1 words with auto-incrementing
// (modulo 2**ADDR_W) addresses. Read data comes out RD_LAT cycles after each
// address issue, back-to-back in address order.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset (RAM contents are kept)
//   bus     : mem_burst_ctrl_if.slave request/data/status bundle
module mem_burst_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 2,
    parameter int LEN_W  = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    mem_burst_ctrl_if.slave  bus
);
    localparam int CNT_W = LEN_W + 1;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_RD_DRAIN, S_WR} state_t;

    state_t                       r_state, w_next;
    logic [ADDR_W-1:0]            r_addr;
    logic [CNT_W-1:0]             r_cnt;      // words still to issue/accept
    logic [DATA_W-1:0]            r_mem [DEPTH];
    logic [RD_LAT-1:0][DATA_W-1:0] r_pipe_d;
    logic [RD_LAT-1:0]            r_vld_pipe;
    logic [DATA_W-1:0]            r_rdata;
    logic                         r_rdata_valid;
    logic                         r_done;
    logic                         r_wrapped;

    logic                         w_accept;
    logic                         w_wr_fire;
    logic                         w_issue;
    logic                         w_last;
    logic [ADDR_W-1:0]            w_issue_addr;

    assign w_accept  = (r_state == S_IDLE) && bus.start;
    assign w_wr_fire = (r_state == S_WR) && bus.wdata_valid;
    // Word 0 of a read is issued on the accepting edge straight from base_addr,
    // so the read latency is counted from the start edge itself.
    assign w_issue      = (w_accept && !bus.wr) || (r_state == S_RD);
    assign w_issue_addr = (r_state == S_IDLE) ? bus.base_addr : r_addr;
    assign w_last       = (r_cnt == CNT_W'(1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.wr)                 w_next = S_WR;
                    else if (bus.burst_len == '0) w_next = S_RD_DRAIN;
                    else                        w_next = S_RD;
                end
            end
            S_RD:       if (w_last) w_next = S_RD_DRAIN;
            // Last word is on the output and nothing is left behind it.
            S_RD_DRAIN: if (r_rdata_valid && (r_vld_pipe == '0)) w_next = S_IDLE;
            S_WR:       if (bus.wdata_valid && w_last) w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // Address/count/wrap tracking.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr    <= '0;
            r_cnt     <= '0;
            r_wrapped <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= (w_next == S_IDLE) && (r_state != S_IDLE);
            if (w_accept) begin
                if (bus.wr) begin
                    r_addr    <= bus.base_addr;
                    r_cnt     <= {1'b0, bus.burst_len} + CNT_W'(1);
                    r_wrapped <= 1'b0;
                end else begin
                    // Word 0 already issued on this edge.
                    r_addr    <= bus.base_addr + ADDR_W'(1);
                    r_cnt     <= {1'b0, bus.burst_len};
                    r_wrapped <= (bus.base_addr == ADDR_MAX) && (bus.burst_len != '0);
                end
            end else if ((r_state == S_RD) || w_wr_fire) begin
                r_addr <= r_addr + ADDR_W'(1);
                r_cnt  <= r_cnt - CNT_W'(1);
                if ((r_addr == ADDR_MAX) && !w_last) r_wrapped <= 1'b1;
            end
        end
    end

    // RAM write port; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (w_wr_fire) r_mem[r_addr] <= bus.wdata;
    end

    // Read pipeline: stage 0 is the RAM output register, r_rdata is the last
    // stage, giving RD_LAT edges from issue to rdata update.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pipe_d      <= '0;
            r_vld_pipe    <= '0;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
        end else begin
            r_vld_pipe[0] <= w_issue;
            if (w_issue) r_pipe_d[0] <= r_mem[w_issue_addr];
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld_pipe[i] <= r_vld_pipe[i-1];
                r_pipe_d[i]   <= r_pipe_d[i-1];
            end
            r_rdata_valid <= r_vld_pipe[RD_LAT-1];
            if (r_vld_pipe[RD_LAT-1]) r_rdata <= r_pipe_d[RD_LAT-1];
        end
    end

    assign bus.wdata_ready = (r_state == S_WR);
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.done        = r_done;
    assign bus.wrapped     = r_wrapped;
    assign bus.rdata       = r_rdata;
    assign bus.rdata_valid = r_rdata_valid;
endmodule

// File: tb/tb_mem_burst_ctrl.sv
// tb_mem_burst_ctrl: directed bench for mem_burst_ctrl (RD_LAT=2, ADDR_W=8).
// Inputs change and outputs are sampled on the falling edge; cycle c of a
// transaction is the cycle following edge T0+c-1, T0 being the start edge.
module tb_mem_burst_ctrl;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;
    localparam int RD_LAT = 2;
    localparam int LEN_W  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_burst_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

    mem_burst_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .LEN_W(LEN_W)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] wr_buf [0:15];
    logic [15:0] rd_buf [0:15];
    int   rd_n, rd_first, rd_contig, rd_done_c, rd_ndone;
    logic rd_busy_c1, rd_busy_done, rd_wrapped_done;
    int   wr_done_c, wr_ndone;
    logic wr_gap_ready, wr_ready_done, wr_busy_done, wr_wrapped_done;

    // Read of len+1 words at a; optionally pulses a write start at cycle inj.
    task automatic do_read(input logic [7:0] a, input logic [3:0] len, input int inj);
        int last_c;
        last_c = -1;
        rd_n = 0; rd_first = -1; rd_contig = 1; rd_done_c = -1; rd_ndone = 0;
        bus.start = 1'b1; bus.wr = 1'b0; bus.base_addr = a; bus.burst_len = len;
        bus.wdata_valid = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin bus.start = 1'b0; rd_busy_c1 = bus.busy; end
            if (c == inj) begin
                bus.start = 1'b1; bus.wr = 1'b1; bus.base_addr = 8'h40;
                bus.wdata = 16'hDEAD; bus.wdata_valid = 1'b1;
            end
            if (c == inj + 1) begin bus.start = 1'b0; bus.wr = 1'b0; bus.wdata_valid = 1'b0; end
            if (bus.rdata_valid) begin
                if (rd_n < 16) rd_buf[rd_n] = bus.rdata;
                if (rd_n == 0) rd_first = c;
                else if (c != last_c + 1) rd_contig = 0;
                last_c = c;
                rd_n++;
            end
            if (bus.done) begin
                rd_ndone++; rd_done_c = c; rd_busy_done = bus.busy; rd_wrapped_done = bus.wrapped;
                break;
            end
        end
    endtask

    // Write of wr_buf[0..len] at a; wdata_valid held low for gap_len cycles from gap_at.
    task automatic do_write(input logic [7:0] a, input logic [3:0] len, input int gap_at, input int gap_len);
        int   idx;
        logic pv, pr;
        idx = 0; pv = 1'b0; pr = 1'b0;
        wr_done_c = -1; wr_ndone = 0; wr_gap_ready = 1'b1;
        bus.start = 1'b1; bus.wr = 1'b1; bus.base_addr = a; bus.burst_len = len;
        bus.wdata_valid = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
            if (pv && pr) idx++;
            if (bus.done) begin
                wr_ndone++; wr_done_c = c; wr_ready_done = bus.wdata_ready;
                wr_busy_done = bus.busy; wr_wrapped_done = bus.wrapped;
                break;
            end
            pr = bus.wdata_ready;
            if (c >= gap_at && c < gap_at + gap_len) begin
                bus.wdata_valid = 1'b0;
                if (!pr) wr_gap_ready = 1'b0;
            end else begin
                bus.wdata_valid = (idx <= int'(len));
                if (idx <= int'(len)) bus.wdata = wr_buf[idx];
            end
            pv = bus.wdata_valid;
        end
        bus.wdata_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if ({bus.busy, bus.done, bus.rdata_valid, bus.wdata_ready, bus.wrapped} !== 5'b0) begin
            n_err++; $display("FAIL reset_flags got %b want 00000",
                {bus.busy, bus.done, bus.rdata_valid, bus.wdata_ready, bus.wrapped}); end
        n_cmp++; if (bus.rdata !== 16'h0) begin n_err++; $display("FAIL reset_rdata got %h want 0000", bus.rdata); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        wr_buf[0] = 16'hBEEF;
        do_write(8'h10, 4'd0, 99, 0);
        n_cmp++; if (wr_done_c !== 2) begin n_err++; $display("FAIL single_wr_done_cycle got %0d want 2", wr_done_c); end
        n_cmp++; if ({wr_busy_done, wr_ready_done} !== 2'b00) begin n_err++;
            $display("FAIL single_wr_done_busy_ready got %b want 00", {wr_busy_done, wr_ready_done}); end
        do_read(8'h10, 4'd0, 0);
        n_cmp++; if (rd_busy_c1 !== 1'b1) begin n_err++; $display("FAIL single_rd_busy got %b want 1", rd_busy_c1); end
        n_cmp++; if (rd_n !== 1) begin n_err++; $display("FAIL single_rd_count got %0d want 1", rd_n); end
        n_cmp++; if (rd_first !== 3) begin n_err++; $display("FAIL single_rd_valid_cycle got %0d want 3", rd_first); end
        n_cmp++; if (rd_buf[0] !== 16'hBEEF) begin n_err++; $display("FAIL single_rd_data got %h want beef", rd_buf[0]); end
        n_cmp++; if (rd_done_c !== 4) begin n_err++; $display("FAIL single_rd_done_cycle got %0d want 4", rd_done_c); end
        n_cmp++; if ({bus.rdata_valid, bus.rdata} !== {1'b0, 16'hBEEF}) begin n_err++;
            $display("FAIL single_rdata_hold got %b/%h want 0/beef", bus.rdata_valid, bus.rdata); end
    endtask

    task automatic test_burst();
        wr_buf[0] = 16'h5555;
        do_write(8'h24, 4'd0, 99, 0);
        wr_buf[0] = 16'h1111; wr_buf[1] = 16'h2222; wr_buf[2] = 16'h3333; wr_buf[3] = 16'h4444;
        do_write(8'h20, 4'd3, 3, 2);
        n_cmp++; if (wr_done_c !== 7) begin n_err++; $display("FAIL burst_wr_done_cycle got %0d want 7", wr_done_c); end
        n_cmp++; if (wr_gap_ready !== 1'b1) begin n_err++; $display("FAIL burst_wr_ready_in_gap got %b want 1", wr_gap_ready); end
        do_read(8'h20, 4'd3, 0);
        n_cmp++; if (rd_n !== 4) begin n_err++; $display("FAIL burst_rd_count got %0d want 4", rd_n); end
        n_cmp++; if (rd_first !== 3 || rd_contig !== 1) begin n_err++;
            $display("FAIL burst_rd_timing got first=%0d contig=%0d want 3/1", rd_first, rd_contig); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (rd_buf[i] !== 16'(16'h1111 * (i + 1))) begin n_err++;
                $display("FAIL burst_rd_data[%0d] got %h want %h", i, rd_buf[i], 16'(16'h1111 * (i + 1))); end
        end
        n_cmp++; if (rd_done_c !== 7) begin n_err++; $display("FAIL burst_rd_done_cycle got %0d want 7", rd_done_c); end
        do_read(8'h24, 4'd0, 0);
        n_cmp++; if (rd_buf[0] !== 16'h5555) begin n_err++; $display("FAIL burst_no_extra_write got %h want 5555", rd_buf[0]); end
    endtask

    task automatic test_wrap();
        wr_buf[0] = 16'hAAA1; wr_buf[1] = 16'hAAA2; wr_buf[2] = 16'hAAA3;
        do_write(8'hFE, 4'd2, 99, 0);
        n_cmp++; if (wr_done_c !== 4) begin n_err++; $display("FAIL wrap_wr_done_cycle got %0d want 4", wr_done_c); end
        n_cmp++; if (wr_wrapped_done !== 1'b1) begin n_err++; $display("FAIL wrap_flag_write got %b want 1", wr_wrapped_done); end
        @(negedge clk);
        n_cmp++; if (bus.wrapped !== 1'b1) begin n_err++; $display("FAIL wrap_flag_sticky got %b want 1", bus.wrapped); end
        do_read(8'hFE, 4'd2, 0);
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (rd_buf[i] !== wr_buf[i]) begin n_err++;
                $display("FAIL wrap_rd_data[%0d] got %h want %h", i, rd_buf[i], wr_buf[i]); end
        end
        n_cmp++; if (rd_wrapped_done !== 1'b1) begin n_err++; $display("FAIL wrap_flag_read got %b want 1", rd_wrapped_done); end
        do_read(8'h00, 4'd0, 0);
        n_cmp++; if (rd_buf[0] !== 16'hAAA3) begin n_err++; $display("FAIL wrap_addr0_data got %h want aaa3", rd_buf[0]); end
        n_cmp++; if (rd_wrapped_done !== 1'b0) begin n_err++; $display("FAIL wrap_flag_clear got %b want 0", rd_wrapped_done); end
        // Last word at 0xFF: the final increment has nothing left, so no wrap.
        wr_buf[0] = 16'hAAA9;
        do_write(8'hFF, 4'd0, 99, 0);
        n_cmp++; if (wr_wrapped_done !== 1'b0) begin n_err++; $display("FAIL wrap_end_at_ff got %b want 0", wr_wrapped_done); end
    endtask

    task automatic test_busy();
        int extra;
        wr_buf[0] = 16'h0A0A;
        do_write(8'h40, 4'd0, 99, 0);
        do_read(8'h20, 4'd3, 2);
        n_cmp++; if (rd_n !== 4 || rd_buf[3] !== 16'h4444) begin n_err++;
            $display("FAIL busy_rd_unaffected got n=%0d last=%h want 4/4444", rd_n, rd_buf[3]); end
        extra = 0;
        repeat (6) begin @(negedge clk); if (bus.done || bus.busy) extra++; end
        n_cmp++; if (extra !== 0) begin n_err++; $display("FAIL busy_extra_activity got %0d want 0", extra); end
        do_read(8'h40, 4'd0, 0);
        n_cmp++; if (rd_buf[0] !== 16'h0A0A) begin n_err++; $display("FAIL busy_ram_untouched got %h want 0a0a", rd_buf[0]); end
    endtask

    task automatic test_back_to_back();
        logic first_busy;
        int   first_done;
        do_read(8'h10, 4'd0, 0);
        first_busy = rd_busy_done; first_done = rd_done_c;
        do_read(8'h20, 4'd3, 0);
        n_cmp++; if (first_done !== 4 || first_busy !== 1'b0) begin n_err++;
            $display("FAIL b2b_first_done got c=%0d busy=%b want 4/0", first_done, first_busy); end
        n_cmp++; if (rd_busy_c1 !== 1'b1) begin n_err++; $display("FAIL b2b_second_busy got %b want 1", rd_busy_c1); end
        n_cmp++; if (rd_first !== 3 || rd_done_c !== 7) begin n_err++;
            $display("FAIL b2b_second_timing got first=%0d done=%0d want 3/7", rd_first, rd_done_c); end
        n_cmp++; if (rd_buf[0] !== 16'h1111) begin n_err++; $display("FAIL b2b_second_data got %h want 1111", rd_buf[0]); end
    endtask

    task automatic test_async_reset();
        int cnt, act;
        for (int i = 0; i < 8; i++) wr_buf[i] = 16'h8000 + 16'(i);
        do_write(8'h80, 4'd7, 99, 0);
        n_cmp++; if (wr_done_c !== 9) begin n_err++; $display("FAIL arst_wr_done_cycle got %0d want 9", wr_done_c); end
        bus.start = 1'b1; bus.wr = 1'b0; bus.base_addr = 8'h80; bus.burst_len = 4'd7;
        cnt = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
            if (bus.rdata_valid) cnt++;
            if (cnt == 2) break;
        end
        n_cmp++; if (cnt !== 2) begin n_err++; $display("FAIL arst_pre_words got %0d want 2", cnt); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({bus.busy, bus.done, bus.rdata_valid, bus.wdata_ready, bus.wrapped} !== 5'b0 || bus.rdata !== 16'h0) begin
            n_err++; $display("FAIL arst_immediate got flags=%b rdata=%h want 00000/0000",
                {bus.busy, bus.done, bus.rdata_valid, bus.wdata_ready, bus.wrapped}, bus.rdata); end
        act = 0;
        repeat (3) begin @(negedge clk); if (bus.done || bus.rdata_valid || bus.busy) act++; end
        rst_n = 1'b1;
        repeat (4) begin @(negedge clk); if (bus.done || bus.rdata_valid || bus.busy) act++; end
        n_cmp++; if (act !== 0) begin n_err++; $display("FAIL arst_no_done got %0d active cycles want 0", act); end
        do_read(8'h80, 4'd7, 0);
        n_cmp++; if (rd_n !== 8) begin n_err++; $display("FAIL arst_readback_count got %0d want 8", rd_n); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (rd_buf[i] !== 16'h8000 + 16'(i)) begin n_err++;
                $display("FAIL arst_readback[%0d] got %h want %h", i, rd_buf[i], 16'h8000 + 16'(i)); end
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.wr = 1'b0; bus.base_addr = '0; bus.burst_len = '0;
        bus.wdata = '0; bus.wdata_valid = 1'b0;
        test_reset();
        test_single();
        test_burst();
        test_wrap();
        test_busy();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end
endmodule
